regfile_port_ctrl: RTL
======================

Name: regfile_port_ctrl

Overview:
Initiator-side controller for the 8-entry x 8-bit register file, which performs either one dual read or one write per clock (r_or_w=0 reads, 1 writes, read data registered). Accepts read requests (two operands) and write requests from the datapath over valid/ready handshakes, buffers writes in a small queue and arbitrates the single regfile port. Returns read data with fixed one-cycle latency, forwarding from queued writes so reads always observe every previously accepted write.

Parameters:
DW, 8, data width (matches regfile word)
AW, 3, register address width
WQ_DEPTH, 2, write-queue entries (>=1)

Ports:
clk  in  1  clock, all state on rising edge
reset_n  in  1  asynchronous active-low reset
rd_req_valid  in  1  read request valid
rd_req_ready  out  1  read request accepted when valid&ready
rd_addr1  in  AW  operand 1 register address
rd_addr2  in  AW  operand 2 register address
rd_rsp_valid  out  1  one-cycle pulse, read data valid
rd_data1  out  DW  operand 1 data
rd_data2  out  DW  operand 2 data
wr_req_valid  in  1  write request valid
wr_req_ready  out  1  write accepted when valid&ready
wr_addr  in  AW  write register address
wr_data  in  DW  write data
rf_r_addr1  out  AW  to regfile r_addr1
rf_r_addr2  out  AW  to regfile r_addr2
rf_w_addr  out  AW  to regfile w_addr
rf_w_data  out  DW  to regfile w_data
rf_r_or_w  out  1  to regfile r_or_w (0 read, 1 write)
rf_data1  in  DW  from regfile data1
rf_data2  in  DW  from regfile data2
wq_count  out  clog2(WQ_DEPTH+1)  queued write count

Behaviour:
- Reset (async, immediate): queue empty, wq_count=0, rd_rsp_valid=0, forward flags/data=0. rf_* outputs driven combinationally: rf_r_or_w=0, all rf addresses/data 0 while idle.
- Write queue: in-order FIFO. wr_req_ready = (wq_count != WQ_DEPTH); no full-bypass. Push and pop in the same cycle leave the count unchanged.
- rd_req_ready = (wq_count != WQ_DEPTH), further qualified by the optional feature.
- Per-cycle arbitration, priority order:
  1. Queue full: pop head. rf_r_or_w=1, rf_w_addr/rf_w_data = head.
  2. Else read accepted: rf_r_or_w=0, rf_r_addr1/2 = rd_addr1/2.
  3. Else queue non-empty: pop head as in 1.
  4. Else idle: rf_r_or_w=0, addresses 0, no response.
- Read latency: accepted in cycle N, rd_rsp_valid=1 in cycle N+1 only. No response backpressure.
- Forwarding at acceptance: per operand, search queue entries valid at the start of cycle N, youngest match wins. A write accepted in the same cycle N is excluded. It is still ordered after the read.
- On a match, register fwd flag=1 and the matching data. Otherwise fwd flag=0.
- In N+1, rd_dataX = fwd flag ? fwd data : rf_dataX.
- rd_data1/2 are forced to 0 whenever rd_rsp_valid=0.
- Reads of the same address on both operands are legal. Both operands are forwarded independently.
- Writes starve while reads are back-to-back until the queue fills. Rule 1 then guarantees drain.
- A reset mid-operation discards queued writes; they never reach the regfile.

Optional Feature:
RF_FWD_EN
- Defined: forwarding as in Behaviour.
- Undefined: no forward registers. rd_req_ready is additionally deasserted while any queued entry's address equals rd_addr1 or rd_addr2. While a read is stalled on such a hazard, the queue head is popped (rule 3). rd_dataX is always rf_dataX in the response cycle.

Test Plan:
1. Assert reset_n=0 mid-cycle -> immediately wq_count=0, rd_rsp_valid=0, rf_r_or_w=0. After release, wr_req_ready=1 and rd_req_ready=1.
2. Write r3=0x5A with no reads -> next edge has rf_r_or_w=1, rf_w_addr=3, rf_w_data=0x5A. A later read (r3,r0) in cycle N gives rd_rsp_valid in N+1 with rd_data1=0x5A and rd_data2=rf_data2.
3. With RF_FWD_EN defined, hold reads of r2 valid; write r2=0x11 then r2=0x22 on consecutive cycles -> the read after both are queued returns rd_data1=0x22 while the queue is still non-empty.
4. With WQ_DEPTH=2 and reads held valid, push 2 writes -> wr_req_ready=0 and rd_req_ready=0. Next cycle has rf_r_or_w=1 (drain) and wq_count=1. The read is then accepted.
5. With 2 writes queued, pulse reset_n low -> wq_count=0 asynchronously and rf_r_or_w never goes 1 for those writes.
6. With RF_FWD_EN undefined, queue r2=0x22, then request read r2 -> rd_req_ready=0 until the write issues. The read is accepted the next cycle and returns rd_data1=0x22.

Source files
------------

// File: rtl/regfile_port_ctrl.sv
// regfile_port_ctrl
//   Initiator-side controller for a single-port 8x8 register file that does
//   either one dual read or one write per clock (read data registered).
//   Writes from the datapath are buffered in an in-order queue. Reads return
//   one cycle after acceptance.
//
//   Compile-time option: RF_FWD_EN
//     defined   : reads forward data from queued writes (youngest match wins)
//     undefined : reads stall while any queued write targets either operand
//
// Ports
//   clk, reset_n                  clock, asynchronous active-low reset
//   rd_req_valid/ready            read request handshake
//   rd_addr1, rd_addr2            operand addresses
//   rd_rsp_valid                  one-cycle response pulse
//   rd_data1, rd_data2            response data (0 when no response)
//   wr_req_valid/ready            write request handshake
//   wr_addr, wr_data              write request payload
//   rf_r_addr1/2, rf_w_addr,
//   rf_w_data, rf_r_or_w          register-file command (0 read, 1 write)
//   rf_data1, rf_data2            register-file read data (valid cycle after read)
//   wq_count                      number of queued writes
module regfile_port_ctrl #(
  parameter int DW       = 8,
  parameter int AW       = 3,
  parameter int WQ_DEPTH = 2,
  localparam int CW      = $clog2(WQ_DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          rd_req_valid,
  output logic          rd_req_ready,
  input  logic [AW-1:0] rd_addr1,
  input  logic [AW-1:0] rd_addr2,
  output logic          rd_rsp_valid,
  output logic [DW-1:0] rd_data1,
  output logic [DW-1:0] rd_data2,
  input  logic          wr_req_valid,
  output logic          wr_req_ready,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  output logic [AW-1:0] rf_r_addr1,
  output logic [AW-1:0] rf_r_addr2,
  output logic [AW-1:0] rf_w_addr,
  output logic [DW-1:0] rf_w_data,
  output logic          rf_r_or_w,
  input  logic [DW-1:0] rf_data1,
  input  logic [DW-1:0] rf_data2,
  output logic [CW-1:0] wq_count
);

  // Queue storage: entry 0 is the head (oldest); entries [0, count) are valid.
  logic [WQ_DEPTH-1:0][AW-1:0] q_addr_r, q_addr_nxt_s, shift_addr_s;
  logic [WQ_DEPTH-1:0][DW-1:0] q_data_r, q_data_nxt_s, shift_data_s;
  logic [CW-1:0]               q_cnt_r, q_cnt_nxt_s, wr_idx_s;
  logic                        full_s, rd_acc_s, wr_acc_s, pop_s;
  logic                        rsp_valid_r;

`ifdef RF_FWD_EN
  // Youngest matching queued entry: returns {hit, data}.
  function automatic logic [DW:0] fwd_lookup(
    input logic [AW-1:0]              addr,
    input logic [WQ_DEPTH-1:0][AW-1:0] qa,
    input logic [WQ_DEPTH-1:0][DW-1:0] qd,
    input logic [CW-1:0]              cnt
  );
    logic [DW:0] res;
    res = '0;
    for (int i = 0; i < WQ_DEPTH; i++) begin
      if ((CW'(i) < cnt) && (qa[i] == addr)) res = {1'b1, qd[i]};
    end
    return res;
  endfunction

  logic          fwd1_r, fwd2_r;
  logic [DW-1:0] fwd_data1_r, fwd_data2_r;
  logic [DW:0]   look1_s, look2_s;

  assign look1_s      = fwd_lookup(rd_addr1, q_addr_r, q_data_r, q_cnt_r);
  assign look2_s      = fwd_lookup(rd_addr2, q_addr_r, q_data_r, q_cnt_r);
  assign rd_req_ready = !full_s;
`else
  // True when any queued entry targets either read operand.
  function automatic logic hazard_check(
    input logic [AW-1:0]              a1,
    input logic [AW-1:0]              a2,
    input logic [WQ_DEPTH-1:0][AW-1:0] qa,
    input logic [CW-1:0]              cnt
  );
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < WQ_DEPTH; i++) begin
      if ((CW'(i) < cnt) && ((qa[i] == a1) || (qa[i] == a2))) hit = 1'b1;
    end
    return hit;
  endfunction

  logic hazard_s;

  assign hazard_s     = hazard_check(rd_addr1, rd_addr2, q_addr_r, q_cnt_r);
  assign rd_req_ready = !full_s && !hazard_s;
`endif

  assign full_s       = (q_cnt_r == CW'(WQ_DEPTH));
  assign wr_req_ready = !full_s;
  assign wr_acc_s     = wr_req_valid && wr_req_ready;
  assign rd_acc_s     = rd_req_valid && rd_req_ready;
  // A full queue always wins the port; otherwise reads beat draining.
  assign pop_s        = full_s || (!rd_acc_s && (q_cnt_r != '0));
  assign wq_count     = q_cnt_r;
  assign rd_rsp_valid = rsp_valid_r;

  // Queue contents after an optional pop (shift toward the head).
  always_comb begin
    shift_addr_s = q_addr_r;
    shift_data_s = q_data_r;
    if (pop_s) begin
      for (int i = 0; i < WQ_DEPTH - 1; i++) begin
        shift_addr_s[i] = q_addr_r[i+1];
        shift_data_s[i] = q_data_r[i+1];
      end
      wr_idx_s = q_cnt_r - CW'(1);
    end else begin
      wr_idx_s = q_cnt_r;
    end
  end

  // Insert the accepted write behind the remaining entries and update count.
  always_comb begin
    for (int i = 0; i < WQ_DEPTH; i++) begin
      q_addr_nxt_s[i] = (wr_acc_s && (CW'(i) == wr_idx_s)) ? wr_addr : shift_addr_s[i];
      q_data_nxt_s[i] = (wr_acc_s && (CW'(i) == wr_idx_s)) ? wr_data : shift_data_s[i];
    end
    case ({wr_acc_s, pop_s})
      2'b10:   q_cnt_nxt_s = q_cnt_r + CW'(1);
      2'b01:   q_cnt_nxt_s = q_cnt_r - CW'(1);
      default: q_cnt_nxt_s = q_cnt_r;
    endcase
  end

  // Queue state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q_addr_r <= '0;
      q_data_r <= '0;
      q_cnt_r  <= '0;
    end else begin
      q_addr_r <= q_addr_nxt_s;
      q_data_r <= q_data_nxt_s;
      q_cnt_r  <= q_cnt_nxt_s;
    end
  end

  // Register-file command: unused fields held at zero.
  always_comb begin
    rf_r_or_w  = 1'b0;
    rf_r_addr1 = '0;
    rf_r_addr2 = '0;
    rf_w_addr  = '0;
    rf_w_data  = '0;
    if (pop_s) begin
      rf_r_or_w = 1'b1;
      rf_w_addr = q_addr_r[0];
      rf_w_data = q_data_r[0];
    end else if (rd_acc_s) begin
      rf_r_addr1 = rd_addr1;
      rf_r_addr2 = rd_addr2;
    end else begin
      rf_r_or_w = 1'b0;
    end
  end

`ifdef RF_FWD_EN
  // Response pulse and forward capture for the read accepted this cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rsp_valid_r <= 1'b0;
      fwd1_r      <= 1'b0;
      fwd2_r      <= 1'b0;
      fwd_data1_r <= '0;
      fwd_data2_r <= '0;
    end else begin
      rsp_valid_r <= rd_acc_s;
      fwd1_r      <= rd_acc_s && look1_s[DW];
      fwd2_r      <= rd_acc_s && look2_s[DW];
      fwd_data1_r <= (rd_acc_s && look1_s[DW]) ? look1_s[DW-1:0] : '0;
      fwd_data2_r <= (rd_acc_s && look2_s[DW]) ? look2_s[DW-1:0] : '0;
    end
  end

  assign rd_data1 = rsp_valid_r ? (fwd1_r ? fwd_data1_r : rf_data1) : '0;
  assign rd_data2 = rsp_valid_r ? (fwd2_r ? fwd_data2_r : rf_data2) : '0;
`else
  // Response pulse for the read accepted this cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rsp_valid_r <= 1'b0;
    end else begin
      rsp_valid_r <= rd_acc_s;
    end
  end

  assign rd_data1 = rsp_valid_r ? rf_data1 : '0;
  assign rd_data2 = rsp_valid_r ? rf_data2 : '0;
`endif

endmodule
